dpram_line_reader: RTL and testbench

Read-side sequencer for the cache's dual-port RAM. On a start command it walks the RAM read port from a base address for a given number of words. The RAM read is combinational, so each word is captured into an output register and streamed to the consumer (refill bus or core load path) over a valid/ready handshake. It is the reader counterpart to the cache's write/fill logic, which owns the RAM write port.

---
 rtl/dpram_line_reader_pkg.sv | 18 +
 rtl/dpram_line_reader.sv | 109 ++++++++++
 tb/tb_dpram_line_reader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_line_reader_pkg.sv
// Shared cache definitions: reader FSM state encoding and RAM geometry defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dpram_line_reader_pkg;

    // RAM geometry shared by the line reader and the fill writer
    localparam int DATABITS_DEF = 32;
    localparam int ADDRBITS_DEF = 5;

    // Reader sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } rd_state_t;

endpackage

// File: rtl/dpram_line_reader.sv
// Walks the dual-port RAM read port from a base address and streams each word out.
// Latency: first word valid 2 cycles after start; one word per cycle with ready held high.
// Backpressure: out_ready low holds out_data/out_last and freezes rdaddr until accepted.
module dpram_line_reader
    import dpram_line_reader_pkg::*;
#(
    parameter int DATABITS = DATABITS_DEF,
    parameter int ADDRBITS = ADDRBITS_DEF,
    parameter int LENBITS  = ADDRBITS + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDRBITS-1:0] startaddr,
    input  logic [LENBITS-1:0]  len,
    output logic                busy,
    output logic                done,
    output logic [ADDRBITS-1:0] rdaddr,
    input  logic [DATABITS-1:0] q,
    output logic [DATABITS-1:0] out_data,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready
);

    rd_state_t          state;
    rd_state_t          state_nxt;
    logic [LENBITS-1:0] remaining;
    logic               load;
    logic               xfer;
    logic               last_word;
    logic               accept_cmd;

    // The output register can take a new word whenever it is empty or being drained this cycle.
    assign load       = (state == ST_STREAM) && (!out_valid || out_ready);
    assign xfer       = out_valid && out_ready;
    assign last_word  = (remaining == LENBITS'(1));
    assign accept_cmd = (state == ST_IDLE) && start && (len != '0);

    // State register; reset drops any in-flight command without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; start is only looked at in IDLE, never queued.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? ST_STREAM : ST_FINISH;
                end
            end
            ST_STREAM: begin
                busy = 1'b1;
                if (load && last_word) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (xfer) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address walk, word counter and the single-stage output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdaddr    <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (accept_cmd) begin
                rdaddr    <= startaddr;
                remaining <= len;
            end
            if (load) begin
                // q is a combinational read of rdaddr, so it is captured in the same cycle.
                out_data  <= q;
                out_valid <= 1'b1;
                out_last  <= last_word;
                rdaddr    <= rdaddr + ADDRBITS'(1);
                remaining <= remaining - LENBITS'(1);
            end else if (xfer) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dpram_line_reader.sv
module tb_dpram_line_reader;

    localparam int DB = 32;
    localparam int AB = 5;
    localparam int LB = AB + 1;
    localparam int N  = 1 << AB;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AB-1:0] startaddr;
    logic [LB-1:0] len;
    logic          busy;
    logic          done;
    logic [AB-1:0] rdaddr;
    logic [DB-1:0] q;
    logic [DB-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;

    logic [DB-1:0] ram [N];
    int            cycle = 0;
    int            checks = 0;
    int            errors = 0;

    assign q = ram[rdaddr];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    dpram_line_reader #(
        .DATABITS (DB),
        .ADDRBITS (AB),
        .LENBITS  (LB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .startaddr (startaddr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rdaddr    (rdaddr),
        .q         (q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command from IDLE and follows it to completion. Expected words come from
    // the RAM image: word i of the command is ram[(a+i) mod N].
    // mode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic run_cmd(input int a, input int n, input int mode, input bit inj_start,
                           input int rst_after, output int acc_cycle);
        logic [DB-1:0] expq[$];
        logic [DB-1:0] hd;
        logic          hl;
        logic [AB-1:0] ha;
        bit            stalled;
        bit            rdy;
        bit            finished;
        int            xfers;
        int            last_x;
        int            c;
        stalled  = 0;
        finished = 0;
        xfers    = 0;
        last_x   = -10;
        hd = '0; hl = 1'b0; ha = '0;
        for (int i = 0; i < n; i++) expq.push_back(ram[(a + i) % N]);

        chk("idle_busy", busy, 0);
        start     = 1'b1;
        startaddr = AB'(a);
        len       = LB'(n);
        acc_cycle = cycle;
        step();
        start = 1'b0;
        c = 1;

        if (n == 0) begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            chk("zero_valid", out_valid, 0);
            step();
            chk("zero_done_end", done, 0);
            chk("zero_valid_end", out_valid, 0);
            return;
        end

        chk("busy_after_start", busy, 1);
        chk("valid_cycle1", out_valid, 0);

        while (c < 40 * n + 40) begin
            if (rst_after > 0 && xfers == rst_after) begin
                reset = 1'b1;
                step();
                chk("rst_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_rdaddr", rdaddr, 0);
                chk("rst_done", done, 0);
                chk("rst_data", out_data, 0);
                reset = 1'b0;
                step();
                chk("rst_idle_done", done, 0);
                chk("rst_idle_busy", busy, 0);
                return;
            end
            if (done) begin
                finished = 1;
                break;
            end
            chk("busy_mid", busy, 1);
            if (c == 2) chk("first_valid_latency", out_valid, 1);
            if (stalled) begin
                chk("stall_data", out_data, hd);
                chk("stall_last", out_last, hl);
                chk("stall_rdaddr", rdaddr, ha);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((c % 4) == 0) || ((c % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (inj_start) begin
                start = (c == 3);
                if (c == 3) begin
                    startaddr = AB'(a + 5);
                    len       = LB'(3);
                end
            end
            stalled = out_valid && !rdy;
            if (stalled) begin
                hd = out_data;
                hl = out_last;
                ha = rdaddr;
            end
            if (out_valid && rdy) begin
                if (expq.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    chk("data", out_data, expq[0]);
                    chk("last", out_last, (expq.size() == 1));
                    void'(expq.pop_front());
                end
                xfers++;
                last_x = c;
            end
            step();
            c++;
        end
        start = 1'b0;

        if (!finished) begin
            chk("timeout_done", 0, 1);
        end else begin
            chk("done_timing", c, last_x + 1);
            chk("words_left", expq.size(), 0);
            chk("final_rdaddr", rdaddr, (a + n) % N);
            chk("end_valid", out_valid, 0);
            chk("end_busy", busy, 0);
            step();
            chk("done_pulse_width", done, 0);
        end
    endtask

    initial begin
        int t0, t1, t2;
        reset     = 1'b1;
        start     = 1'b0;
        startaddr = '0;
        len       = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) ram[i] = 32'h100 + i;
        step();
        step();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_last", out_last, 0);
        chk("reset_data", out_data, 0);
        chk("reset_rdaddr", rdaddr, 0);
        reset = 1'b0;
        step();

        // basic burst and the same burst under backpressure
        run_cmd(3, 4, 0, 0, 0, t0);
        run_cmd(3, 4, 1, 0, 0, t0);

        // randomized RAM contents for the remaining scenarios
        for (int i = 0; i < N; i++) ram[i] = $urandom;

        // address wrap and full depth
        run_cmd(30, 4, 0, 0, 0, t0);
        run_cmd(7, 32, 0, 0, 0, t0);
        run_cmd(7, 32, 2, 0, 0, t0);

        // zero length, then a start pulsed during STREAM
        run_cmd(5, 0, 0, 0, 0, t0);
        run_cmd(10, 6, 0, 1, 0, t0);

        // reset after 2 of 8 words, then a fresh command
        run_cmd(12, 8, 0, 0, 2, t0);
        run_cmd(12, 8, 2, 0, 0, t0);

        // single-word commands back to back
        run_cmd(4, 1, 0, 0, 0, t0);
        run_cmd(9, 1, 0, 0, 0, t1);
        run_cmd(31, 1, 0, 0, 0, t2);
        chk("b2b_spacing_1", t1 - t0, 4);
        chk("b2b_spacing_2", t2 - t1, 4);

        // random commands with random backpressure
        repeat (12) begin
            run_cmd(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N)), 2, 0, 0, t0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
